// File: rtl/tilemap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tilemap_pkg
// Description : Shared definitions for the tilemap index RAM arbiter.
//               Grant tag encoding and tilemap geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package tilemap_pkg;

    // Tilemap geometry: 22 x 17 cells, addressed as {row[4:0], col[4:0]}
    localparam int TILEMAP_CELLS_X = 22;
    localparam int TILEMAP_CELLS_Y = 17;

    // Grant tag recorded for the cycle after a RAM access is issued
    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_VID  = 2'd1;
    localparam logic [1:0] GNT_CPU  = 2'd2;
    localparam logic [1:0] GNT_CTL  = 2'd3;

endpackage : tilemap_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin picker with a single pointer bit.
//               req[0]/gnt[0] = CPU, req[1]/gnt[1] = control engine.
//               When both request, the pointer decides; a lone requester
//               always wins. After any grant the pointer moves to the other
//               requester; with no grant it holds.
// Ports       : clk, reset  - clock, synchronous active-high reset
//               req[1:0]    - eligible requesters (already masked)
//               gnt[1:0]    - one-hot grant, combinational
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 0: req[0] has priority, 1: req[1] has priority
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
        if (gnt[0]) begin
            ptr_d = 1'b1;
        end else if (gnt[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/tilemapram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tilemapram_arbiter
// Description : Arbitrates the single-port tilemap index RAM between the
//               video fetch path (absolute priority), the tilemap control
//               engine and the CPU (round-robin between the two). The control
//               engine can lock out new CPU grants with ctl_lock.
// Ports       : clk, reset                    - clock, sync active-high reset
//               vid_req/vid_addr               - video read request
//               vid_data/vid_valid             - video read response
//               ctl_req/wr/addr/din/lock       - control engine request
//               ctl_dout/ctl_ack               - control engine response
//               cpu_req/wr/addr/din            - CPU request
//               cpu_dout/cpu_ack/cpu_wait      - CPU response
//               ram_addr/ram_we/ram_din        - RAM pins, combinational
//               ram_dout                       - RAM data, 1-cycle latency
// Revision    : 1.0 - initial release
// ============================================================================
module tilemapram_arbiter
    import tilemap_pkg::*;
#(
    parameter int RAM_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vid_req,
    input  logic [RAM_WIDTH-1:0] vid_addr,
    output logic [7:0]           vid_data,
    output logic                 vid_valid,
    input  logic                 ctl_req,
    input  logic                 ctl_wr,
    input  logic [RAM_WIDTH-1:0] ctl_addr,
    input  logic [7:0]           ctl_din,
    input  logic                 ctl_lock,
    output logic [7:0]           ctl_dout,
    output logic                 ctl_ack,
    input  logic                 cpu_req,
    input  logic                 cpu_wr,
    input  logic [RAM_WIDTH-1:0] cpu_addr,
    input  logic [7:0]           cpu_din,
    output logic [7:0]           cpu_dout,
    output logic                 cpu_ack,
    output logic                 cpu_wait,
    output logic [RAM_WIDTH-1:0] ram_addr,
    output logic                 ram_we,
    output logic [7:0]           ram_din,
    input  logic [7:0]           ram_dout
);

    logic [1:0] gnt_q, gnt_d;
    logic       wr_q, wr_d;
    logic [7:0] cpu_dout_q, cpu_dout_d;
    logic [7:0] ctl_dout_q, ctl_dout_d;

    logic       w_cpu_elig;
    logic       w_ctl_elig;
    logic [1:0] w_rr_req;
    logic [1:0] w_rr_gnt;
    logic       w_cpu_rd_done;
    logic       w_ctl_rd_done;

    // A requester whose access was granted last cycle is in its ack cycle and
    // must not be re-granted yet, even though its req is still high.
    assign w_cpu_elig = cpu_req & ~ctl_lock & (gnt_q != GNT_CPU);
    assign w_ctl_elig = ctl_req & (gnt_q != GNT_CTL);

    // Video takes the slot outright; masking here keeps the rr pointer frozen.
    assign w_rr_req = {w_ctl_elig, w_cpu_elig} & {2{~vid_req}};

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .req   (w_rr_req),
        .gnt   (w_rr_gnt)
    );

    // Grant selection and RAM pin mux
    always_comb begin
        gnt_d    = GNT_NONE;
        wr_d     = 1'b0;
        ram_addr = '0;
        ram_we   = 1'b0;
        ram_din  = 8'h00;
        if (vid_req) begin
            gnt_d    = GNT_VID;
            ram_addr = vid_addr;
        end else if (w_rr_gnt[0]) begin
            gnt_d    = GNT_CPU;
            wr_d     = cpu_wr;
            ram_addr = cpu_addr;
            ram_we   = cpu_wr;
            ram_din  = cpu_din;
        end else if (w_rr_gnt[1]) begin
            gnt_d    = GNT_CTL;
            wr_d     = ctl_wr;
            ram_addr = ctl_addr;
            ram_we   = ctl_wr;
            ram_din  = ctl_din;
        end
        // No RAM write may slip through while the system is in reset
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    // Responses for the access granted last cycle; gating with reset drops an
    // ack that was in flight when reset arrived.
    always_comb begin
        vid_valid     = (gnt_q == GNT_VID) & ~reset;
        cpu_ack       = (gnt_q == GNT_CPU) & ~reset;
        ctl_ack       = (gnt_q == GNT_CTL) & ~reset;
        cpu_wait      = cpu_req & ~cpu_ack;
        w_cpu_rd_done = cpu_ack & ~wr_q;
        w_ctl_rd_done = ctl_ack & ~wr_q;

        vid_data   = vid_valid ? ram_dout : 8'h00;
        // Read data is visible during the ack cycle and held afterwards
        cpu_dout_d = w_cpu_rd_done ? ram_dout : cpu_dout_q;
        ctl_dout_d = w_ctl_rd_done ? ram_dout : ctl_dout_q;
        cpu_dout   = cpu_dout_d;
        ctl_dout   = ctl_dout_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q      <= GNT_NONE;
            wr_q       <= 1'b0;
            cpu_dout_q <= 8'h00;
            ctl_dout_q <= 8'h00;
        end else begin
            gnt_q      <= gnt_d;
            wr_q       <= wr_d;
            cpu_dout_q <= cpu_dout_d;
            ctl_dout_q <= ctl_dout_d;
        end
    end

endmodule : tilemapram_arbiter
`default_nettype wire

// File: tb/tb_tilemapram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tilemapram_arbiter
// Description : Directed self-checking bench for tilemapram_arbiter with a
//               behavioural registered-output RAM attached to the RAM pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tilemapram_arbiter;

    localparam int RAM_WIDTH = 10;

    logic                 clk;
    logic                 reset;
    logic                 vid_req;
    logic [RAM_WIDTH-1:0] vid_addr;
    logic [7:0]           vid_data;
    logic                 vid_valid;
    logic                 ctl_req;
    logic                 ctl_wr;
    logic [RAM_WIDTH-1:0] ctl_addr;
    logic [7:0]           ctl_din;
    logic                 ctl_lock;
    logic [7:0]           ctl_dout;
    logic                 ctl_ack;
    logic                 cpu_req;
    logic                 cpu_wr;
    logic [RAM_WIDTH-1:0] cpu_addr;
    logic [7:0]           cpu_din;
    logic [7:0]           cpu_dout;
    logic                 cpu_ack;
    logic                 cpu_wait;
    logic [RAM_WIDTH-1:0] ram_addr;
    logic                 ram_we;
    logic [7:0]           ram_din;
    logic [7:0]           ram_dout;

    int checks = 0;
    int errors = 0;

    tilemapram_arbiter #(.RAM_WIDTH(RAM_WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_valid (vid_valid),
        .ctl_req   (ctl_req),
        .ctl_wr    (ctl_wr),
        .ctl_addr  (ctl_addr),
        .ctl_din   (ctl_din),
        .ctl_lock  (ctl_lock),
        .ctl_dout  (ctl_dout),
        .ctl_ack   (ctl_ack),
        .cpu_req   (cpu_req),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_ack   (cpu_ack),
        .cpu_wait  (cpu_wait),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port RAM with registered read output
    logic [7:0] mem [0:(1<<RAM_WIDTH)-1] = '{default: 8'h00};
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cpu_last;
        int ctl_last;
        int last_who;
        int n_acks;

        reset = 1'b1; vid_req = 1'b0; vid_addr = '0;
        ctl_req = 1'b0; ctl_wr = 1'b0; ctl_addr = '0; ctl_din = 8'h00; ctl_lock = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 10'h025; cpu_din = 8'hA5;

        // ---- reset behaviour ----
        repeat (2) tick;
        chk("rst_cpu_wait", cpu_wait, 1);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_ctl_ack", ctl_ack, 0);
        chk("rst_vid_valid", vid_valid, 0);
        cpu_req = 1'b0;
        tick;
        reset = 1'b0;
        #1;
        chk("rst_cpu_dout", cpu_dout, 0);
        chk("rst_ctl_dout", ctl_dout, 0);
        chk("rst_vid_data", vid_data, 0);
        chk("idle_ram_addr", ram_addr, 0);
        chk("idle_ram_din", ram_din, 0);

        // ---- CPU write then read of 0x025 ----
        cpu_req = 1'b1; cpu_wr = 1'b1;
        #1;
        chk("wr_ram_we", ram_we, 1);
        chk("wr_ram_addr", ram_addr, 10'h025);
        chk("wr_ram_din", ram_din, 8'hA5);
        chk("wr_cpu_wait", cpu_wait, 1);
        tick;
        chk("wr_cpu_ack", cpu_ack, 1);
        chk("wr_cpu_wait_ack", cpu_wait, 0);
        cpu_req = 1'b0;
        tick;
        cpu_req = 1'b1; cpu_wr = 1'b0;
        #1;
        chk("rd_cpu_wait", cpu_wait, 1);
        chk("rd_ram_we", ram_we, 0);
        chk("rd_cpu_ack_early", cpu_ack, 0);
        tick;
        chk("rd_cpu_ack", cpu_ack, 1);
        chk("rd_cpu_dout", cpu_dout, 8'hA5);
        cpu_req = 1'b0;
        tick;
        chk("rd_cpu_dout_held", cpu_dout, 8'hA5);
        chk("rd_cpu_ack_done", cpu_ack, 0);
        chk("rd_cpu_wait_done", cpu_wait, 0);

        // Restart so the round-robin pointer is back at CPU
        reset = 1'b1;
        tick; tick;
        reset = 1'b0;

        // ---- simultaneous vid, cpu and ctl ----
        vid_req = 1'b1; vid_addr = 10'h111;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 10'h025;
        ctl_req = 1'b1; ctl_wr = 1'b0; ctl_addr = 10'h225;
        #1;
        chk("tri_c0_addr", ram_addr, 10'h111);
        chk("tri_c0_we", ram_we, 0);
        tick;
        vid_req = 1'b0; vid_addr = '0;
        #1;
        chk("tri_c1_vid_valid", vid_valid, 1);
        chk("tri_c1_addr", ram_addr, 10'h025);
        chk("tri_c1_cpu_ack", cpu_ack, 0);
        chk("tri_c1_ctl_ack", ctl_ack, 0);
        tick;
        chk("tri_c2_cpu_ack", cpu_ack, 1);
        chk("tri_c2_cpu_dout", cpu_dout, 8'hA5);
        chk("tri_c2_addr", ram_addr, 10'h225);
        chk("tri_c2_vid_valid", vid_valid, 0);
        cpu_req = 1'b0;
        tick;
        chk("tri_c3_ctl_ack", ctl_ack, 1);
        chk("tri_c3_cpu_ack", cpu_ack, 0);
        ctl_req = 1'b0;
        tick;
        chk("idle2_ram_addr", ram_addr, 0);
        chk("idle2_ctl_ack", ctl_ack, 0);

        // ---- ctl_lock blocks the CPU ----
        ctl_lock = 1'b1; ctl_addr = 10'h025;
        cpu_req = 1'b1; ctl_req = 1'b1;
        for (int t = 0; t < 6; t++) begin
            if (t > 0) tick;
            #1;
            chk("lock_ctl_ack", ctl_ack, (t % 2 == 1) ? 1 : 0);
            chk("lock_cpu_ack", cpu_ack, 0);
            chk("lock_cpu_wait", cpu_wait, 1);
        end
        chk("lock_ctl_dout", ctl_dout, 8'hA5);
        tick;
        ctl_lock = 1'b0; ctl_req = 1'b0;
        #1;
        chk("unlock_grant_addr", ram_addr, 10'h025);
        tick;
        chk("unlock_cpu_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        tick;

        // ---- throughput: video 1 in 4, cpu and ctl back-to-back ----
        cpu_req = 1'b1; ctl_req = 1'b1; cpu_wr = 1'b0; ctl_wr = 1'b0;
        cpu_addr = 10'h025; ctl_addr = 10'h025;
        cpu_last = 0; ctl_last = 0; last_who = 0; n_acks = 0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) tick;
            vid_req = (c % 4 == 0); vid_addr = 10'h0AA;
            #1;
            chk("tp_both_ack", {31'd0, cpu_ack & ctl_ack}, 0);
            if (cpu_ack) begin
                chk("tp_alt_cpu", (last_who == 1) ? 1 : 0, 0);
                last_who = 1; cpu_last = c; n_acks++;
            end
            if (ctl_ack) begin
                chk("tp_alt_ctl", (last_who == 2) ? 1 : 0, 0);
                last_who = 2; ctl_last = c; n_acks++;
            end
            chk("tp_cpu_latency", (c - cpu_last <= 3) ? 1 : 0, 1);
            chk("tp_ctl_latency", (c - ctl_last <= 3) ? 1 : 0, 1);
        end
        chk("tp_ack_count", (n_acks >= 60) ? 1 : 0, 1);
        chk("tp_cpu_dout", cpu_dout, 8'hA5);
        chk("tp_ctl_dout", ctl_dout, 8'hA5);
        tick;
        cpu_req = 1'b0; ctl_req = 1'b0; vid_req = 1'b0;
        tick; tick;

        // ---- reset the cycle after a CPU grant ----
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 10'h3FF; cpu_din = 8'h77;
        #1;
        chk("rm_ram_we", ram_we, 1);
        tick;
        reset = 1'b1; cpu_req = 1'b0;
        #1;
        chk("rm_cpu_ack_dropped", cpu_ack, 0);
        chk("rm_ram_we_rst", ram_we, 0);
        tick;
        chk("rm_cpu_ack", cpu_ack, 0);
        chk("rm_cpu_dout", cpu_dout, 0);
        chk("rm_ctl_dout", ctl_dout, 0);
        chk("rm_vid_valid", vid_valid, 0);
        chk("rm_vid_data", vid_data, 0);
        chk("rm_ctl_ack", ctl_ack, 0);
        reset = 1'b0;
        tick;

        // ---- video reads what ctl wrote the cycle before ----
        ctl_req = 1'b1; ctl_wr = 1'b1; ctl_addr = 10'h155; ctl_din = 8'h3C;
        #1;
        chk("vw_ram_we", ram_we, 1);
        chk("vw_ram_din", ram_din, 8'h3C);
        tick;
        chk("vw_ctl_ack", ctl_ack, 1);
        ctl_req = 1'b0; ctl_wr = 1'b0;
        vid_req = 1'b1; vid_addr = 10'h155;
        #1;
        chk("vw_vid_addr", ram_addr, 10'h155);
        chk("vw_vid_we", ram_we, 0);
        tick;
        vid_req = 1'b0;
        #1;
        chk("vw_vid_valid", vid_valid, 1);
        chk("vw_vid_data", vid_data, 8'h3C);
        tick;
        chk("vw_vid_valid_off", vid_valid, 0);
        chk("vw_vid_data_off", vid_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_tilemapram_arbiter
`default_nettype wire
